fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register of the 24-bit pipelined core.
- Holds the PC, drives the instruction-memory address, and registers the fetched word, its PC and a valid bit into the decode stage.
- Consumes the hazard unit's stall and the branch-taken redirect (the flush of the younger stages) and issues the bubbles those events require.
- Contains a small RUN/HALT state machine and a saturating fetch counter for debug.

---
 rtl/fetch_stage_if.sv | 30 +++
 rtl/fetch_stage.sv | 97 +++++++++
 tb/tb_fetch_stage.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Bus bundle between the fetch stage and its surroundings: hazard/branch control,
// instruction memory and the IF/ID outputs toward decode.
interface fetch_stage_if #(
    parameter int unsigned PC_W    = 24,
    parameter int unsigned INSTR_W = 24,
    parameter int unsigned CNT_W   = 16
);
    logic               stall;
    logic               branchTaken;
    logic [PC_W-1:0]    branchTarget;
    logic [PC_W-1:0]    imemAddr;
    logic [INSTR_W-1:0] imemData;
    logic [INSTR_W-1:0] instrD;
    logic [PC_W-1:0]    pcD;
    logic               validD;
    logic               halted;
    logic [CNT_W-1:0]   fetchCount;

    // Core side: hazard unit, branch unit, instruction memory and decode.
    modport master (
        output stall, branchTaken, branchTarget, imemData,
        input  imemAddr, instrD, pcD, validD, halted, fetchCount
    );

    // Fetch stage side.
    modport slave (
        input  stall, branchTaken, branchTarget, imemData,
        output imemAddr, instrD, pcD, validD, halted, fetchCount
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, RUN/HALT control and a
// saturating count of instructions delivered to decode.
module fetch_stage #(
    parameter int unsigned        PC_W       = 24,
    parameter int unsigned        INSTR_W    = 24,
    parameter logic [PC_W-1:0]    RESET_PC   = '0,
    parameter logic [INSTR_W-1:0] HALT_INSTR = {INSTR_W{1'b1}},
    parameter int unsigned        CNT_W      = 16
) (
    input logic          clk,
    input logic          rst,
    fetch_stage_if.slave bus
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             state, state_next;
    logic [PC_W-1:0]    pc_f, pc_f_next;
    logic [INSTR_W-1:0] instr_d, instr_d_next;
    logic [PC_W-1:0]    pc_d, pc_d_next;
    logic               valid_d, valid_d_next;
    logic [CNT_W-1:0]   fetch_cnt, fetch_cnt_next;
    logic               deliver;

    // State and IF/ID register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_RUN;
            pc_f      <= RESET_PC;
            instr_d   <= '0;
            pc_d      <= '0;
            valid_d   <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            state     <= state_next;
            pc_f      <= pc_f_next;
            instr_d   <= instr_d_next;
            pc_d      <= pc_d_next;
            valid_d   <= valid_d_next;
            fetch_cnt <= fetch_cnt_next;
        end
    end

    // Next-state: redirect beats stall, stall freezes everything, HALT issues bubbles.
    always_comb begin
        state_next   = state;
        pc_f_next    = pc_f;
        instr_d_next = instr_d;
        pc_d_next    = pc_d;
        valid_d_next = valid_d;
        deliver      = 1'b0;

        if (bus.branchTaken) begin
            pc_f_next    = bus.branchTarget;
            instr_d_next = '0;
            pc_d_next    = '0;
            valid_d_next = 1'b0;
            state_next   = ST_RUN;
        end else if (bus.stall) begin
            state_next = state;
        end else begin
            case (state)
                ST_HALT: begin
                    instr_d_next = '0;
                    valid_d_next = 1'b0;
                end
                default: begin
                    instr_d_next = bus.imemData;
                    pc_d_next    = pc_f;
                    valid_d_next = 1'b1;
                    deliver      = 1'b1;
                    // The halt word still reaches decode once; the PC parks on it.
                    if (bus.imemData == HALT_INSTR) begin
                        state_next = ST_HALT;
                    end else begin
                        pc_f_next = pc_f + PC_W'(1);
                    end
                end
            endcase
        end

        fetch_cnt_next = (deliver && (fetch_cnt != CNT_MAX)) ? fetch_cnt + CNT_W'(1) : fetch_cnt;
    end

    assign bus.imemAddr   = pc_f;
    assign bus.instrD     = instr_d;
    assign bus.pcD        = pc_d;
    assign bus.validD     = valid_d;
    assign bus.halted     = (state == ST_HALT);
    assign bus.fetchCount = fetch_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: main 24-bit instance plus a 4-bit-PC instance
// for wrap and a 2-bit-counter instance for saturation.
module tb_fetch_stage;

    localparam int unsigned PC_W    = 24;
    localparam int unsigned INSTR_W = 24;
    localparam int unsigned CNT_W   = 16;

    logic clk;
    logic rst;
    int   tests;
    int   failed;

    logic [INSTR_W-1:0] mem [0:255];

    fetch_stage_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) m_if ();
    fetch_stage_if #(.PC_W(4),    .INSTR_W(INSTR_W), .CNT_W(CNT_W)) w_if ();
    fetch_stage_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(2))     c_if ();

    fetch_stage #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bus(m_if.slave));
    fetch_stage #(.PC_W(4), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut_wrap (
        .clk(clk), .rst(rst), .bus(w_if.slave));
    fetch_stage #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(2)) dut_cnt (
        .clk(clk), .rst(rst), .bus(c_if.slave));

    always_comb m_if.imemData = mem[m_if.imemAddr[7:0]];
    always_comb w_if.imemData = 24'h200 + 24'(w_if.imemAddr);
    always_comb c_if.imemData = 24'h300;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_d(input string tag, input logic [23:0] pc, input logic [23:0] ins,
                           input logic v, input logic [15:0] cnt);
        check({tag, ".pcD"}, 64'(m_if.pcD), 64'(pc));
        check({tag, ".instrD"}, 64'(m_if.instrD), 64'(ins));
        check({tag, ".validD"}, 64'(m_if.validD), 64'(v));
        check({tag, ".cnt"}, 64'(m_if.fetchCount), 64'(cnt));
    endtask

    initial begin
        tests = 0;
        failed = 0;
        for (int i = 0; i < 256; i++) mem[i] = 24'h100 + 24'(i);
        rst = 1'b0;
        m_if.stall = 1'b0; m_if.branchTaken = 1'b0; m_if.branchTarget = 24'h0;
        w_if.stall = 1'b0; w_if.branchTaken = 1'b0; w_if.branchTarget = 4'h0;
        c_if.stall = 1'b0; c_if.branchTaken = 1'b0; c_if.branchTarget = 24'h0;

        // Reset values
        #2;
        check_d("reset", 24'h0, 24'h0, 1'b0, 16'd0);
        check("reset.imemAddr", 64'(m_if.imemAddr), 64'h0);
        check("reset.halted", 64'(m_if.halted), 64'h0);
        step();
        rst = 1'b1;

        // Free-running fetch
        for (int i = 0; i < 5; i++) begin
            step();
            check_d($sformatf("run%0d", i), 24'(i), 24'h100 + 24'(i), 1'b1, 16'(i + 1));
        end
        check("run.imemAddr", 64'(m_if.imemAddr), 64'h5);

        // Stall two edges with pcF=5
        m_if.stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check_d($sformatf("stall%0d", i), 24'h4, 24'h104, 1'b1, 16'd5);
            check("stall.imemAddr", 64'(m_if.imemAddr), 64'h5);
        end
        m_if.stall = 1'b0;
        step();
        check_d("unstall", 24'h5, 24'h105, 1'b1, 16'd6);

        // Branch together with stall: branch wins
        m_if.stall = 1'b1; m_if.branchTaken = 1'b1; m_if.branchTarget = 24'h40;
        step();
        check_d("br_stall", 24'h0, 24'h0, 1'b0, 16'd6);
        check("br_stall.imemAddr", 64'(m_if.imemAddr), 64'h40);
        m_if.stall = 1'b0; m_if.branchTaken = 1'b0; m_if.branchTarget = 24'h77;
        step();
        check_d("br_target", 24'h40, 24'h140, 1'b1, 16'd7);

        // Async reset, then halt at address 3
        mem[3] = 24'hFFFFFF;
        #2;
        rst = 1'b0;
        #1;
        check_d("rst2", 24'h0, 24'h0, 1'b0, 16'd0);
        check("rst2.imemAddr", 64'(m_if.imemAddr), 64'h0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_d($sformatf("pre_halt%0d", i), 24'(i), 24'h100 + 24'(i), 1'b1, 16'(i + 1));
            check("pre_halt.halted", 64'(m_if.halted), 64'h0);
        end
        step();
        check_d("halt_word", 24'h3, 24'hFFFFFF, 1'b1, 16'd4);
        check("halt_word.halted", 64'(m_if.halted), 64'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_d($sformatf("halted%0d", i), 24'h3, 24'h0, 1'b0, 16'd4);
            check("halted.halted", 64'(m_if.halted), 64'h1);
            check("halted.imemAddr", 64'(m_if.imemAddr), 64'h3);
        end

        // Branch out of HALT
        mem[8'h12] = 24'hFFFFFF;
        m_if.branchTaken = 1'b1; m_if.branchTarget = 24'h10;
        step();
        check("resume.halted", 64'(m_if.halted), 64'h0);
        check_d("resume", 24'h0, 24'h0, 1'b0, 16'd4);
        m_if.branchTaken = 1'b0;
        step();
        check_d("resume2", 24'h10, 24'h110, 1'b1, 16'd5);
        step();
        check_d("resume3", 24'h11, 24'h111, 1'b1, 16'd6);
        step();
        check_d("halt2", 24'h12, 24'hFFFFFF, 1'b1, 16'd7);
        step();
        check("halt2.halted", 64'(m_if.halted), 64'h1);
        check("halt2.cnt", 64'(m_if.fetchCount), 64'd7);

        // Async reset mid-cycle while halted
        #2;
        rst = 1'b0;
        #1;
        check_d("rst3", 24'h0, 24'h0, 1'b0, 16'd0);
        check("rst3.halted", 64'(m_if.halted), 64'h0);
        check("rst3.imemAddr", 64'(m_if.imemAddr), 64'h0);
        step();
        rst = 1'b1;
        step();
        check_d("rst3_rel", 24'h0, 24'h100, 1'b1, 16'd1);
        check("cnt2.first", 64'(c_if.fetchCount), 64'd1);

        // PC wrap on the 4-bit instance and counter saturation on the 2-bit one
        w_if.branchTaken = 1'b1; w_if.branchTarget = 4'hF;
        step();
        check("wrap.imemAddr", 64'(w_if.imemAddr), 64'hF);
        check("wrap.valid0", 64'(w_if.validD), 64'h0);
        w_if.branchTaken = 1'b0; w_if.branchTarget = 4'h3;
        step();
        check("wrap.pcF", 64'(w_if.pcD), 64'hF);
        check("wrap.instrF", 64'(w_if.instrD), 64'h20F);
        check("wrap.addr0", 64'(w_if.imemAddr), 64'h0);
        step();
        check("wrap.pc0", 64'(w_if.pcD), 64'h0);
        check("wrap.instr0", 64'(w_if.instrD), 64'h200);
        check("cnt2.sat", 64'(c_if.fetchCount), 64'd3);
        step();
        check("cnt2.hold", 64'(c_if.fetchCount), 64'd3);
        check("cnt2.valid", 64'(c_if.validD), 64'h1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
